// File: rtl/router_pkg.sv
// Shared types and constants for the token router transmit path.
package router_pkg;

  localparam int PKT_W = 55;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RELEASE
  } tx_arb_state_t;

endpackage

// File: rtl/tx_arbiter_if.sv
// Valid/ready handshake between the arbiter and the serial transmitter.
interface tx_arbiter_if
  import router_pkg::*;
#(
  parameter int PKT_W = router_pkg::PKT_W
) ();

  logic [PKT_W-1:0] TX_Data;
  logic             TX_Data_Valid;
  logic             TX_Ready;

  modport master (
    output TX_Data,
    output TX_Data_Valid,
    input  TX_Ready
  );

  modport slave (
    input  TX_Data,
    input  TX_Data_Valid,
    output TX_Ready
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick
  import router_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  int              idx;
  logic [ID_W-1:0] idx_v;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    idx_v      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = ID_W'(idx);
      if (!any && req[idx_v]) begin
        any               = 1'b1;
        gnt_id            = idx_v;
        gnt_onehot[idx_v] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin owner of the serial transmitter: grants one requester, holds the
// captured packet valid for a full frame, then releases and re-arbitrates.
module tx_arbiter
  import router_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PKT_W          = router_pkg::PKT_W,
  parameter int TX_HOLD_CYCLES = 600
) (
  input  logic                       Clk_S,
  input  logic                       Rst,
  input  logic [NUM_REQ*PKT_W-1:0]   Req_Data,
  input  logic [NUM_REQ-1:0]         Req_Valid,
  output logic [NUM_REQ-1:0]         Req_Ack,
  tx_arbiter_if.master               tx,
  output logic [$clog2(NUM_REQ)-1:0] Grant_Id,
  output logic                       Busy,
  output logic                       Tx_Done
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TX_HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  tx_arb_state_t      state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    rr_ptr;
  logic [PKT_W-1:0]   tx_data_q;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic               do_grant, do_done, cnt_clr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (Req_Valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (gnt_any)
  );

  always_ff @(posedge Clk_S) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Requests are only looked at in IDLE, and only while the transmitter is ready.
  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    do_done   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (tx.TX_Ready && gnt_any) begin
          do_grant  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (!tx.TX_Ready) begin
          cnt_clr   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (cnt == CNT_LAST) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (tx.TX_Ready) begin
          do_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_S) begin
    if (Rst) begin
      Req_Ack   <= '0;
      Tx_Done   <= 1'b0;
      tx_data_q <= '0;
      Grant_Id  <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      Req_Ack <= do_grant ? gnt_onehot : '0;
      Tx_Done <= do_done;
      if (do_grant) begin
        tx_data_q <= Req_Data[gnt_id*PKT_W +: PKT_W];
        Grant_Id  <= gnt_id;
        rr_ptr    <= (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
      end
      // Counter parks at its terminal value; the next LOAD->HOLD clears it.
      if (cnt_clr)                           cnt <= '0;
      else if (state == HOLD && cnt != CNT_LAST) cnt <= cnt + 1'b1;
    end
  end

  assign tx.TX_Data       = tx_data_q;
  assign tx.TX_Data_Valid = (state == LOAD) || (state == HOLD);
  assign Busy             = (state != IDLE);

endmodule
